// File: rtl/level_debouncer.sv
// Switch debouncer feeding the mode-5 counter's level input.
// A raw bouncing input is synchronized into the clock domain. It then has to agree for
// DEBOUNCE_CYCLES consecutive synchronized cycles before the registered level flips.
// The registered level comes with one-cycle rise/fall ticks. FSM state is exposed for debug.
// Optional build macro: LEVEL_DEBOUNCER_SYNC3_EN adds a third synchronizer stage.
module level_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sw_raw,
  output logic       level,
  output logic       rise_tick,
  output logic       fall_tick,
  output logic [1:0] state_reg_out,
  output logic [1:0] state_next_out
);

  typedef enum logic [1:0] {
    StZero  = 2'b00,
    StWait1 = 2'b01,
    StOne   = 2'b10,
    StWait0 = 2'b11
  } state_e;

  // Exit point of qualification; cnt is compared before incrementing, so it never wraps.
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic s1_q, s2_q;
  logic sync_in;

`ifdef LEVEL_DEBOUNCER_SYNC3_EN
  logic s3_q;

  // Three-flop synchronizer for sw_raw.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sw_raw;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign sync_in = s3_q;
`else
  // Two-flop synchronizer for sw_raw.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= sw_raw;
      s2_q <= s1_q;
    end
  end

  assign sync_in = s2_q;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  // Next-state, stability counter and registered-output next values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StZero: begin
        if (sync_in) begin
          state_d = StWait1;
          cnt_d   = '0;
        end
      end
      StWait1: begin
        if (!sync_in) begin
          state_d = StZero;
        end else if (cnt_q == CntMax) begin
          state_d = StOne;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StOne: begin
        if (!sync_in) begin
          state_d = StWait0;
          cnt_d   = '0;
        end
      end
      StWait0: begin
        if (sync_in) begin
          state_d = StOne;
        end else if (cnt_q == CntMax) begin
          state_d = StZero;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = StZero;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered from the next state so level and tick land on the same edge.
    level_d = (state_d == StOne) || (state_d == StWait0);
    rise_d  = (state_q == StWait1) && (state_d == StOne);
    fall_d  = (state_q == StWait0) && (state_d == StZero);
  end

  // FSM, counter and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StZero;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level          = level_q;
  assign rise_tick      = rise_q;
  assign fall_tick      = fall_q;
  assign state_reg_out  = state_q;
  assign state_next_out = state_d;

endmodule

// File: tb/tb_level_debouncer.sv
// Self-checking bench for level_debouncer: directed scenarios plus randomized bouncing input,
// all compared against a run-length reference model of the debouncing rule.
module tb_level_debouncer;

  localparam int unsigned D = 4;
`ifdef LEVEL_DEBOUNCER_SYNC3_EN
  localparam int unsigned SYNC = 3;
`else
  localparam int unsigned SYNC = 2;
`endif
  // Edge (1 = first edge sampling the new raw value) at which level and tick appear.
  localparam int unsigned LAT = D + SYNC + 1;

  logic       clock;
  logic       reset;
  logic       sw_raw;
  logic       level;
  logic       rise_tick;
  logic       fall_tick;
  logic [1:0] state_reg_out;
  logic [1:0] state_next_out;

  int n_tests = 0;
  int n_fail  = 0;

  level_debouncer #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (3)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .sw_raw        (sw_raw),
    .level         (level),
    .rise_tick     (rise_tick),
    .fall_tick     (fall_tick),
    .state_reg_out (state_reg_out),
    .state_next_out(state_next_out)
  );

  initial clock = 1'b1;
  always #10 clock = ~clock;

  // Reference model: raw samples are seen by the filter SYNC edges later. Level flips once
  // D+1 consecutive seen samples disagree with it; any agreeing sample clears the run.
  logic q[$];
  logic m_level;
  int   m_run;
  logic m_rise, m_fall;

  function automatic logic [1:0] st_of(input logic lv, input int run);
    if (run == 0) return lv ? 2'b10 : 2'b00;
    return lv ? 2'b11 : 2'b01;
  endfunction

  function automatic logic [1:0] next_st(input logic lv, input int run, input logic obs);
    if (obs == lv) return st_of(lv, 0);
    if (run + 1 == int'(D) + 1) return st_of(obs, 0);
    return st_of(lv, run + 1);
  endfunction

  function automatic logic [6:0] exp_vec();
    return {m_level, m_rise, m_fall, st_of(m_level, m_run), next_st(m_level, m_run, q[0])};
  endfunction

  function automatic logic [6:0] dut_vec();
    return {level, rise_tick, fall_tick, state_reg_out, state_next_out};
  endfunction

  task automatic model_reset();
    q = {};
    for (int i = 0; i < int'(SYNC); i++) q.push_back(1'b0);
    m_level = 1'b0;
    m_run   = 0;
    m_rise  = 1'b0;
    m_fall  = 1'b0;
  endtask

  // Drive sw_raw at the falling edge, advance the model at the rising edge, settle 1 ns.
  task automatic step(input logic v);
    logic obs;
    @(negedge clock);
    sw_raw = v;
    @(posedge clock);
    obs = q.pop_front();
    q.push_back(v);
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (obs != m_level) begin
      m_run++;
      if (m_run == int'(D) + 1) begin
        m_level = obs;
        m_run   = 0;
        m_rise  = obs;
        m_fall  = ~obs;
      end
    end else begin
      m_run = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    sw_raw = 1'b0;
    model_reset();
    for (int t = 0; t < 3; t++) begin
      #15;
      n_tests++;
      if (dut_vec() !== 7'b0) begin
        n_fail++;
        $display("FAIL reset_hold t=%0t got=%b want=%b", $time, dut_vec(), 7'b0);
      end
    end
    #5 reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(1'b0);
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL reset_idle k=%0d got=%b want=%b", k, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_steady_rise();
    int nrise = 0;
    int redge = -1;
    for (int k = 1; k <= int'(LAT) + 4; k++) begin
      step(1'b1);
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL steady_rise k=%0d got=%b want=%b", k, dut_vec(), exp_vec());
      end
      if (rise_tick) begin
        nrise++;
        redge = k;
      end
    end
    n_tests++;
    if (redge != int'(LAT) || nrise != 1 || level !== 1'b1 || state_reg_out !== 2'b10) begin
      n_fail++;
      $display("FAIL steady_rise_edge edge=%0d n=%0d lvl=%b st=%b want edge=%0d n=1 lvl=1 st=10",
               redge, nrise, level, state_reg_out, LAT);
    end
  endtask

  task automatic test_bounce_rise();
    logic pat[$];
    int   nrise = 0;
    int   redge = -1;
    // Start from stable low.
    for (int k = 0; k < int'(LAT) + 2; k++) step(1'b0);
    pat = {1'b1, 1'b1, 1'b0};
    for (int k = 0; k < int'(LAT) + 4; k++) pat.push_back(1'b1);
    for (int k = 0; k < pat.size(); k++) begin
      step(pat[k]);
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL bounce_rise k=%0d got=%b want=%b", k, dut_vec(), exp_vec());
      end
      if (rise_tick) begin
        nrise++;
        redge = k - 2;  // edges counted from the final 0->1 of sw_raw
      end
    end
    n_tests++;
    if (nrise != 1 || redge != int'(LAT) || level !== 1'b1) begin
      n_fail++;
      $display("FAIL bounce_rise_edge n=%0d edge=%0d lvl=%b want n=1 edge=%0d lvl=1",
               nrise, redge, level, LAT);
    end
  endtask

  task automatic test_glitch_fall();
    logic pat[$];
    int   nfall = 0;
    int   fedge = -1;
    pat = {1'b0, 1'b0, 1'b1};
    for (int k = 0; k < int'(LAT) + 4; k++) pat.push_back(1'b0);
    for (int k = 0; k < pat.size(); k++) begin
      step(pat[k]);
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL glitch_fall k=%0d got=%b want=%b", k, dut_vec(), exp_vec());
      end
      if (fall_tick) begin
        nfall++;
        fedge = k - 2;
      end
      if (rise_tick) begin
        n_tests++;
        n_fail++;
        $display("FAIL glitch_fall_rise k=%0d got=1 want=0", k);
      end
    end
    n_tests++;
    if (nfall != 1 || fedge != int'(LAT) || level !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_fall_edge n=%0d edge=%0d lvl=%b want n=1 edge=%0d lvl=0",
               nfall, fedge, level, LAT);
    end
  endtask

  task automatic test_reset_mid_qual();
    int redge = -1;
    // Enter rise qualification and advance to cnt=2.
    for (int k = 0; k < int'(SYNC) + 3; k++) step(1'b1);
    n_tests++;
    if (state_reg_out !== 2'b01) begin
      n_fail++;
      $display("FAIL midqual_state got=%b want=01", state_reg_out);
    end
    #4 reset = 1'b0;
    #1;
    n_tests++;
    if (dut_vec() !== 7'b0) begin
      n_fail++;
      $display("FAIL async_reset got=%b want=%b", dut_vec(), 7'b0);
    end
    model_reset();
    @(posedge clock);
    #5 reset = 1'b1;
    for (int k = 1; k <= int'(LAT) + 2; k++) begin
      step(1'b1);
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL reset_requal k=%0d got=%b want=%b", k, dut_vec(), exp_vec());
      end
      if (rise_tick) redge = k;
    end
    n_tests++;
    if (redge != int'(LAT)) begin
      n_fail++;
      $display("FAIL reset_requal_edge got=%0d want=%0d", redge, LAT);
    end
  endtask

  task automatic test_random();
    logic v = 1'b0;
    for (int seg = 0; seg < 60; seg++) begin
      int len = int'($urandom_range(1, D + 5));
      v = ~v;
      for (int k = 0; k < len; k++) begin
        step(v);
        n_tests++;
        if (dut_vec() !== exp_vec()) begin
          n_fail++;
          $display("FAIL random seg=%0d k=%0d got=%b want=%b", seg, k, dut_vec(), exp_vec());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_steady_rise();
    test_bounce_rise();
    test_glitch_fall();
    test_reset_mid_qual();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/level_debouncer.md
Name: level_debouncer

Overview:
- Upstream conditioning stage for the mode-5 counter's `level` input.
- Takes a raw, asynchronous, bouncing switch/button signal and synchronizes it into the `clock` domain.
- Filters bounce with a stability counter and FSM, then drives a clean registered `level` plus one-cycle edge ticks that the counter consumes directly.
- Exposes current and next FSM state for debug, in the same style as the counter's state outputs.

Parameters:
- DEBOUNCE_CYCLES, 4: number of consecutive synchronized-stable cycles required before `level` changes; legal range is 1 or more.
- CNT_W, 3: stability counter width; must satisfy 2**CNT_W >= DEBOUNCE_CYCLES.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted); clears all state immediately, independent of clock.
- sw_raw  in  1  raw asynchronous switch input, may bounce.
- level  out  1  debounced level; registered; feeds the counter's `level` input.
- rise_tick  out  1  one-cycle pulse when `level` goes 0->1.
- fall_tick  out  1  one-cycle pulse when `level` goes 1->0.
- state_reg_out  out  2  current FSM state (debug).
- state_next_out  out  2  combinational next FSM state (debug).

Behaviour:
- Synchronizer: two flops, sw_raw -> s1 -> s2. The FSM sees only s2.
- States:
  - ZERO=2'b00: stable low.
  - WAIT1=2'b01: qualifying a rise.
  - ONE=2'b10: stable high.
  - WAIT0=2'b11: qualifying a fall.
- Transitions (cnt is the CNT_W-bit stability counter):
  - ZERO: s2=1 -> WAIT1, cnt<=0. Otherwise stay.
  - WAIT1:
    - s2=0 -> ZERO (bounce, abort).
    - else cnt==DEBOUNCE_CYCLES-1 -> ONE.
    - else cnt<=cnt+1.
  - ONE: s2=0 -> WAIT0, cnt<=0. Otherwise stay.
  - WAIT0:
    - s2=1 -> ONE (bounce, abort).
    - else cnt==DEBOUNCE_CYCLES-1 -> ZERO.
    - else cnt<=cnt+1.
- Outputs (all registered):
  - level=1 exactly when state is ONE or WAIT0.
  - rise_tick=1 for the single cycle after a WAIT1->ONE transition.
  - fall_tick=1 for the single cycle after a WAIT0->ZERO transition.
  - Each tick coincides with the first cycle of the new level.
- Latency: counting the first rising edge that samples sw_raw at its new value as edge 1, `level` and the tick update at edge DEBOUNCE_CYCLES+3 (edge 7 for the default).
- Bounce handling:
  - Any opposite-value s2 sample during WAIT1/WAIT0 aborts qualification; `level` stays unchanged and no tick is produced.
  - Requalification restarts from cnt=0.
- cnt never wraps: it is compared before incrementing and saturates at the exit point.
- Reset:
  - Asserting reset (low), at any time including mid-qualification, forces: s1=s2=0, state=ZERO, cnt=0, level=0, rise_tick=0, fall_tick=0, state_reg_out=2'b00.
  - After deassertion, an sw_raw already high is qualified normally from ZERO and produces a rise_tick.
- state_next_out follows the transition rules combinationally. During reset it equals the next state computed from ZERO.
- rise_tick and fall_tick are never both 1, and a tick never repeats without an intervening opposite tick.

Optional Feature:
- Macro: LEVEL_DEBOUNCER_SYNC3_EN.
- Defined: a third synchronizer flop is inserted (sw_raw -> s1 -> s2 -> s3; the FSM uses s3). Latency becomes DEBOUNCE_CYCLES+4 edges (8 for the default). All other behaviour is identical; s3 is also reset to 0.
- Undefined: two-flop synchronizer with latency as specified above.

Test Plan:
1. Reset low for 50 ns, clock period 20 ns, sw_raw=0, then reset high -> level=0, both ticks 0, state_reg_out=00 throughout.
2. sw_raw 0->1 held steady (DEBOUNCE_CYCLES=4) -> state sequence 00,01,10; level=1 and a single-cycle rise_tick at edge 7 after the change; state stays 10.
3. sw_raw goes high for 2 cycles, low for 1, then high steadily -> WAIT1 aborts to ZERO with no tick; level rises only at edge 7 after the final rise; exactly one rise_tick.
4. From level=1, sw_raw 1->0 with a 1-cycle high glitch at cycle 3 -> WAIT0 aborts to ONE, then requalifies; exactly one fall_tick; level=0 at edge 7 after the last transition.
5. Reset pulsed low during WAIT1 (cnt=2) -> all outputs 0 and state 00 immediately, asynchronously. sw_raw still high after release -> rise_tick at edge 7 after release.
6. Compile with LEVEL_DEBOUNCER_SYNC3_EN and rerun scenario 2 -> level and rise_tick at edge 8; all other checks unchanged.
